// File: rtl/pipe_mem_reader_pkg.sv
// pipe_mem_reader_pkg: shared widths and FSM state type for the result-memory
// readback engine.
//   DATA_W_DEF / ADDR_W_DEF : defaults matching the pipeline regbank and memory
//   state_t                 : readback FSM states
package pipe_mem_reader_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_mem_reader_if.sv
// pipe_mem_reader_if: memory read port plus output stream of the readback engine.
//   mem_re/mem_raddr/mem_rdata : synchronous read port, data one cycle after mem_re
//   out_valid/out_ready        : stream handshake
//   out_data/out_addr          : streamed word and the address it came from
// master = reader side, slave = memory + stream consumer side.
interface pipe_mem_reader_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              mem_re;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output mem_re, mem_raddr, out_valid, out_data, out_addr,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_re, mem_raddr, out_valid, out_data, out_addr,
        output mem_rdata, out_ready
    );
endinterface

// File: rtl/pipe_skid_fifo.sv
// pipe_skid_fifo: 2-entry FIFO of {addr, data} between the memory read port and
// the output stream.
//   clk, rst_n             : clock, async active-low reset
//   push, push_addr/data   : write an entry
//   pop                    : retire the head entry
//   full, empty            : occupancy flags
//   head_addr, head_data   : head entry (zero after reset)
// Push and pop in the same cycle are both performed, so a full FIFO can accept a
// push when it is also popped.
module pipe_skid_fifo #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data
);

    logic [1:0][ADDR_W-1:0] addr_q;
    logic [1:0][DATA_W-1:0] data_q;
    logic                   wr_ptr;
    logic                   rd_ptr;
    logic [1:0]             level;
    logic                   pop_en;
    logic                   push_en;

    assign full      = (level == 2'd2);
    assign empty     = (level == 2'd0);
    assign pop_en    = pop && !empty;
    assign push_en   = push && (!full || pop_en);
    assign head_addr = addr_q[rd_ptr];
    assign head_data = data_q[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            data_q <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            level  <= 2'd0;
        end else begin
            if (push_en) begin
                addr_q[wr_ptr] <= push_addr;
                data_q[wr_ptr] <= push_data;
                wr_ptr         <= ~wr_ptr;
            end
            if (pop_en) rd_ptr <= ~rd_ptr;
            case ({push_en, pop_en})
                2'b10:   level <= level + 2'd1;
                2'b01:   level <= level - 2'd1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pipe_mem_reader.sv
// pipe_mem_reader: reads a contiguous, wrapping address range from the result
// memory and streams each {addr, data} word out with valid/ready, keeping a
// running mod-2**DATA_W checksum of streamed words.
//   clk, rst_n        : clock, async active-low reset
//   start             : command strobe, only honoured while idle
//   base_addr, count  : first address and word count (0..2**ADDR_W)
//   busy, done        : command in progress / one-cycle completion pulse
//   checksum          : sum of words streamed by the current/last command
//   bus (master)      : memory read port and output stream
module pipe_mem_reader
    import pipe_mem_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [ADDR_W:0]    count,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  checksum,
    pipe_mem_reader_if.master  bus
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W:0]   remaining;
    logic              inflight;
    logic [ADDR_W-1:0] issue_addr;
    logic              full, empty;
    logic [1:0]        occ;
    logic [2:0]        load;
    logic              xfer;
    logic              issue;
    logic              accept;
    logic              last_xfer;

    assign occ    = full ? 2'd2 : (empty ? 2'd0 : 2'd1);
    assign load   = {1'b0, occ} + {2'b00, inflight};
    assign xfer   = bus.out_valid && bus.out_ready;
    assign accept = (state == IDLE) && start;

    // A word leaving this cycle frees a slot at the same edge, so count it
    // when deciding whether another read fits; without this the stream
    // stalls every third cycle.
    assign issue  = (state == READ) && (load < (xfer ? 3'd3 : 3'd2));

    // In DRAIN nothing more is issued: the word leaving with nothing behind
    // it (no second entry, nothing in flight) is the last one.
    assign last_xfer = xfer && !inflight && (occ == 2'd1);

    assign bus.mem_re    = issue;
    assign bus.mem_raddr = cur_addr;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start && (count != '0)) state_n = READ;
            READ:    if (issue && (remaining == (ADDR_W+1)'(1))) state_n = DRAIN;
            DRAIN:   if (last_xfer) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr   <= '0;
            remaining  <= '0;
            inflight   <= 1'b0;
            issue_addr <= '0;
            checksum   <= '0;
            done       <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) issue_addr <= cur_addr;

            if (accept) begin
                cur_addr  <= base_addr;
                remaining <= count;
            end else if (issue) begin
                cur_addr  <= cur_addr + 1'b1;
                remaining <= remaining - 1'b1;
            end

            if (accept)    checksum <= '0;
            else if (xfer) checksum <= checksum + bus.out_data;

            done <= (accept && (count == '0)) || ((state == DRAIN) && last_xfer);
        end
    end

    pipe_skid_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_addr (issue_addr),
        .push_data (bus.mem_rdata),
        .pop       (bus.out_ready),
        .full      (full),
        .empty     (empty),
        .head_addr (bus.out_addr),
        .head_data (bus.out_data)
    );

    assign bus.out_valid = !empty;

endmodule
